// File: rtl/alu_pkg.sv
// Shared op-code and state definitions for the sequential execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;
  localparam logic [3:0] OP_MTHI  = 4'b1110;
  localparam logic [3:0] OP_MTLO  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative 1-bit/cycle shift-add multiplier and restoring divider on operand
// magnitudes; hi/lo are the sign-corrected values of the step that raises done.
module alu_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_r, div_r, neg_lo_r, neg_hi_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r, m_r;
  logic [WIDTH-1:0] mag_a_s, mag_b_s, step_hi_s, step_lo_s;
  logic [WIDTH:0]   sum_s, shift_s;
  logic             ge_s;
  logic [2*WIDTH-1:0] prod_s;

  // One iteration step plus final sign fix-up of the stepped values
  always_comb begin
    mag_a_s   = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b_s   = (is_signed && b[WIDTH-1]) ? -b : b;
    sum_s     = {1'b0, hi_r} + {1'b0, (lo_r[0] ? m_r : {WIDTH{1'b0}})};
    shift_s   = {hi_r, lo_r[WIDTH-1]};
    ge_s      = (shift_s >= {1'b0, m_r});
    step_hi_s = sum_s[WIDTH:1];
    step_lo_s = {sum_s[0], lo_r[WIDTH-1:1]};
    prod_s    = {2*WIDTH{1'b0}};
    hi        = {WIDTH{1'b0}};
    lo        = {WIDTH{1'b0}};
    if (div_r) begin
      // remainder after subtraction is below the divisor, so WIDTH bits suffice
      step_hi_s = ge_s ? (shift_s[WIDTH-1:0] - m_r) : shift_s[WIDTH-1:0];
      step_lo_s = {lo_r[WIDTH-2:0], ge_s};
      hi        = neg_hi_r ? -step_hi_s : step_hi_s;
      lo        = neg_lo_r ? -step_lo_s : step_lo_s;
    end else begin
      prod_s = {step_hi_s, step_lo_s};
      prod_s = neg_lo_r ? -prod_s : prod_s;
      hi     = prod_s[2*WIDTH-1:WIDTH];
      lo     = prod_s[WIDTH-1:0];
    end
    done = busy_r && (cnt_r == LAST);
  end

  // Operand load on start, then WIDTH iterations unless flushed
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r   <= 1'b0;
      div_r    <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      m_r      <= {WIDTH{1'b0}};
    end else if (start) begin
      busy_r   <= 1'b1;
      div_r    <= is_div;
      neg_lo_r <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_r <= is_signed && a[WIDTH-1];
      cnt_r    <= {CW{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= is_div ? mag_a_s : mag_b_s;
      m_r      <= is_div ? mag_b_s : mag_a_s;
    end else if (flush) begin
      busy_r <= 1'b0;
    end else if (busy_r) begin
      hi_r  <= step_hi_s;
      lo_r  <= step_lo_s;
      cnt_r <= cnt_r + CW'(1'b1);
      if (cnt_r == LAST) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential execute-stage ALU: single-cycle logic/arith ops, iterative
// mul/div into HI/LO, and HI/LO moves. Issue is blocked while mul/div runs.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             unsig,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_zero
);

  state_e state_r, state_nx_s;
  logic   in_ready_r, out_valid_r, overflow_r, div_zero_r;
  logic [WIDTH-1:0] result_r, hi_r, lo_r;
  logic   accept_s, muldiv_s, div_zero_s, start_s, flush_s, md_signed_s;
  logic   sc_ovf_s, core_done_s;
  logic [WIDTH-1:0] sum_s, diff_s, sc_result_s, core_hi_s, core_lo_s;

  // Issue decode and mul/div control
  always_comb begin
    accept_s    = in_valid && (state_r == S_IDLE);
    muldiv_s    = (op[3:2] == 2'b10);
    md_signed_s = !(unsig || op[0]);
    div_zero_s  = muldiv_s && op[1] && (b == {WIDTH{1'b0}});
    start_s     = accept_s && muldiv_s && !div_zero_s;
    flush_s     = abort && (state_r != S_IDLE);
  end

  // Single-cycle datapath; overflow only for signed ADD/SUB
  always_comb begin
    sum_s       = a + b;
    diff_s      = a - b;
    sc_result_s = {WIDTH{1'b0}};
    sc_ovf_s    = 1'b0;
    case (op)
      OP_AND:  sc_result_s = a & b;
      OP_OR:   sc_result_s = a | b;
      OP_ADD: begin
        sc_result_s = sum_s;
        sc_ovf_s    = !unsig && (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: sc_result_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  sc_result_s = ~(a | b);
      OP_XOR:  sc_result_s = a ^ b;
      OP_SUB: begin
        sc_result_s = diff_s;
        sc_ovf_s    = !unsig && (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_result_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: sc_result_s = hi_r;
      OP_MFLO: sc_result_s = lo_r;
      OP_MTHI: sc_result_s = a;
      OP_MTLO: sc_result_s = a;
      default: sc_result_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && muldiv_s) begin
          state_nx_s = div_zero_s ? S_DONE : S_BUSY;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (abort) begin
          state_nx_s = S_IDLE;
        end else if (core_done_s) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_BUSY;
        end
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State and ready registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s == S_IDLE);
    end
  end

  // HI/LO and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      overflow_r  <= 1'b0;
      div_zero_r  <= 1'b0;
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
    end else begin
      out_valid_r <= 1'b0;
      if (accept_s && !muldiv_s) begin
        out_valid_r <= 1'b1;
        result_r    <= sc_result_s;
        overflow_r  <= sc_ovf_s;
        div_zero_r  <= 1'b0;
        case (op)
          OP_MTHI: hi_r <= a;
          OP_MTLO: lo_r <= a;
          default: ;
        endcase
      end else if (accept_s && div_zero_s) begin
        out_valid_r <= 1'b1;
        result_r    <= {WIDTH{1'b1}};
        overflow_r  <= 1'b0;
        div_zero_r  <= 1'b1;
        hi_r        <= a;
        lo_r        <= {WIDTH{1'b1}};
      end else if ((state_r == S_BUSY) && !abort && core_done_s) begin
        out_valid_r <= 1'b1;
        result_r    <= core_lo_s;
        overflow_r  <= 1'b0;
        div_zero_r  <= 1'b0;
        hi_r        <= core_hi_s;
        lo_r        <= core_lo_s;
      end
    end
  end

  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clock     (clock),
    .reset     (reset),
    .start     (start_s),
    .flush     (flush_s),
    .is_div    (op[1]),
    .is_signed (md_signed_s),
    .a         (a),
    .b         (b),
    .done      (core_done_s),
    .hi        (core_hi_s),
    .lo        (core_lo_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign overflow  = overflow_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq with a 64-bit arithmetic reference
// model; a negedge compare process checks every cycle of the WIDTH=32 instance.
module tb_alu_seq;
  import alu_pkg::*;

  logic clock = 1'b0;
  logic reset, in_valid, unsig, abort;
  logic [3:0] op;
  logic [31:0] a, b;
  logic in_ready, out_valid, overflow, div_zero;
  logic [31:0] result;

  logic in_valid8, unsig8, abort8;
  logic [3:0] op8;
  logic [7:0] a8, b8, result8;
  logic in_ready8, out_valid8, overflow8, div_zero8;

  always #5 clock = ~clock;

  alu_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .unsig(unsig), .a(a), .b(b), .abort(abort),
    .out_valid(out_valid), .result(result), .overflow(overflow), .div_zero(div_zero)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .unsig(unsig8), .a(a8), .b(b8), .abort(abort8),
    .out_valid(out_valid8), .result(result8), .overflow(overflow8), .div_zero(div_zero8)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf, dz, wr_hi, wr_lo;
    logic [31:0] hi, lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit run_chk = 1'b0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: wide signed/unsigned arithmetic; cyc field holds latency in edges
  function automatic exp_t model(input logic [3:0] o, input logic u, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, r;
    logic [63:0] p;
    e = '{default: 0};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_AND:  e.res = x & y;
      OP_OR:   e.res = x | y;
      OP_NOR:  e.res = ~(x | y);
      OP_XOR:  e.res = x ^ y;
      OP_ADD, OP_SUB: begin
        r = (o == OP_ADD) ? sx + sy : sx - sy;
        e.res = r[31:0];
        e.ovf = !u && (r != longint'($signed(r[31:0])));
      end
      OP_SLT:  e.res = (sx < sy) ? 32'd1 : 32'd0;
      OP_SLTU: e.res = (x < y) ? 32'd1 : 32'd0;
      OP_MULT, OP_MULTU: begin
        if (u || o[0]) p = {32'h0, x} * {32'h0, y};
        else p = sx * sy;
        e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0];
        e.wr_hi = 1'b1; e.wr_lo = 1'b1; e.cyc = 32;
      end
      OP_DIV, OP_DIVU: begin
        e.wr_hi = 1'b1; e.wr_lo = 1'b1;
        if (y == 32'h0) begin
          e.dz = 1'b1; e.hi = x; e.lo = 32'hFFFF_FFFF; e.res = 32'hFFFF_FFFF;
        end else begin
          if (u || o[0]) begin
            e.lo = x / y; e.hi = x % y;
          end else begin
            r = sx / sy; e.lo = r[31:0];
            r = sx % sy; e.hi = r[31:0];
          end
          e.res = e.lo; e.cyc = 32;
        end
      end
      OP_MFHI: e.res = m_hi;
      OP_MFLO: e.res = m_lo;
      OP_MTHI: begin e.res = x; e.wr_hi = 1'b1; e.hi = x; end
      OP_MTLO: begin e.res = x; e.wr_lo = 1'b1; e.lo = x; end
      default: e.res = 32'h0;
    endcase
    return e;
  endfunction

  // Cycle-by-cycle comparison against the model queue
  always @(negedge clock) begin : cmp
    exp_t e;
    if (!reset && run_chk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        tests++; fails++;
        $display("FAIL missed_out_valid: got none expected cycle %0d", e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("out_valid", out_valid, 1'b1);
        check("result", result, e.res);
        check("overflow", overflow, e.ovf);
        check("div_zero", div_zero, e.dz);
        if (e.wr_hi) m_hi = e.hi;
        if (e.wr_lo) m_lo = e.lo;
      end else begin
        check("spurious_out_valid", out_valid, 1'b0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [3:0] o, input logic u, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int g = 0;
    while (!in_ready && g < 100) begin
      in_valid = 1'($urandom); op = 4'($urandom); a = $urandom; b = $urandom;
      @(negedge clock); g++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1");
    end
    in_valid = 1'b1; op = o; unsig = u; a = x; b = y;
    @(posedge clock); #1;
    e = model(o, u, x, y);
    e.cyc = e.cyc + cyc;
    exp_q.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic abort_op(input logic [3:0] o, input logic u, input logic [31:0] x, input logic [31:0] y, input int k);
    issue(o, u, x, (y == 32'h0) ? 32'h1 : y);
    repeat (k - 1) @(negedge clock);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clock);
    check("abort_ready", in_ready, 1'b1);
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] r, output int lat);
    int g = 0;
    while (!in_ready8 && g < 50) begin @(negedge clock); g++; end
    in_valid8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clock);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 50) begin @(negedge clock); lat++; end
    r = result8;
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [7:0] r8;
    int lat;
    reset = 1'b1; in_valid = 1'b0; op = 4'h0; unsig = 1'b0; a = 32'h0; b = 32'h0; abort = 1'b0;
    in_valid8 = 1'b0; op8 = 4'h0; unsig8 = 1'b0; a8 = 8'h0; b8 = 8'h0; abort8 = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_div_zero", div_zero, 1'b0);
    check("rst8_in_ready", in_ready8, 1'b1);
    run_chk = 1'b1;

    issue(OP_MFHI, 1'b0, rnd(), rnd());
    issue(OP_MFLO, 1'b0, rnd(), rnd());

    e = model(OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1);
    check("pin_add_res", e.res, 32'h8000_0000);
    check("pin_add_ovf", e.ovf, 1'b1);
    e = model(OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1);
    check("pin_addu_ovf", e.ovf, 1'b0);
    issue(OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1);
    issue(OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1);
    issue(OP_SUB, 1'b0, 32'h8000_0000, 32'h1);

    e = model(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1);
    check("pin_slt", e.res, 32'h1);
    e = model(OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'h1);
    check("pin_sltu", e.res, 32'h0);
    issue(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1);
    issue(OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'h1);

    e = model(OP_MULT, 1'b0, 32'hFFFF_FFFE, 32'h3);
    check("pin_mult_hi", e.hi, 32'hFFFF_FFFF);
    check("pin_mult_lo", e.lo, 32'hFFFF_FFFA);
    check("pin_mult_lat", e.cyc, 32);
    issue(OP_MULT, 1'b0, 32'hFFFF_FFFE, 32'h3);
    issue(OP_MFHI, 1'b0, rnd(), rnd());
    e = model(OP_MULTU, 1'b0, 32'hFFFF_FFFE, 32'h3);
    check("pin_multu_hi", e.hi, 32'h2);
    issue(OP_MULTU, 1'b0, 32'hFFFF_FFFE, 32'h3);
    issue(OP_MFHI, 1'b0, rnd(), rnd());

    e = model(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'h2);
    check("pin_div_lo", e.lo, 32'hFFFF_FFFD);
    check("pin_div_hi", e.hi, 32'hFFFF_FFFF);
    issue(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'h2);
    issue(OP_MFHI, 1'b0, rnd(), rnd());
    e = model(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    check("pin_divmin_lo", e.lo, 32'h8000_0000);
    check("pin_divmin_hi", e.hi, 32'h0);
    issue(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_MFHI, 1'b0, rnd(), rnd());

    e = model(OP_DIVU, 1'b0, 32'h7, 32'h0);
    check("pin_div0_hi", e.hi, 32'h7);
    check("pin_div0_lo", e.lo, 32'hFFFF_FFFF);
    check("pin_div0_lat", e.cyc, 0);
    issue(OP_DIVU, 1'b0, 32'h7, 32'h0);
    issue(OP_MFHI, 1'b0, rnd(), rnd());

    issue(OP_MTHI, 1'b0, 32'h1234_5678, rnd());
    abort_op(OP_MULT, 1'b0, 32'h55, 32'h77, 10);
    issue(OP_MFHI, 1'b0, rnd(), rnd());
    abort_op(OP_DIVU, 1'b1, rnd(), rnd(), 32);

    issue(OP_DIV, 1'b0, 32'd100, 32'd3);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clock);
    check("midrst_in_ready", in_ready, 1'b1);
    issue(OP_MFLO, 1'b0, rnd(), rnd());

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0)
        abort_op(4'(8 + $urandom_range(0, 3)), 1'($urandom), rnd(), rnd(), $urandom_range(1, 32));
      else
        issue(4'($urandom_range(0, 15)), 1'($urandom), rnd(), rnd());
      if ($urandom_range(0, 5) == 0) @(negedge clock);
    end
    repeat (40) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    issue8(OP_MULTU, 8'hFF, 8'hFF, r8, lat);
    check("w8_multu_lat", lat, 9);
    check("w8_multu_lo", r8, 8'h01);
    issue8(OP_MFHI, 8'h00, 8'h00, r8, lat);
    check("w8_mfhi", r8, 8'hFE);
    check("w8_mfhi_lat", lat, 1);
    issue8(OP_MTHI, 8'h5A, 8'h00, r8, lat);
    issue8(OP_MFHI, 8'h00, 8'h00, r8, lat);
    check("w8_mthi_mfhi", r8, 8'h5A);
    issue8(OP_DIV, 8'h80, 8'hFF, r8, lat);
    check("w8_divmin_lo", r8, 8'h80);
    issue8(OP_MFHI, 8'h00, 8'h00, r8, lat);
    check("w8_divmin_hi", r8, 8'h00);
    issue8(OP_MULT, 8'hFE, 8'h03, r8, lat);
    check("w8_mult_lo", r8, 8'hFA);
    issue8(OP_MFHI, 8'h00, 8'h00, r8, lat);
    check("w8_mult_hi", r8, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
